// File: rtl/cpu_pkg.sv
// cpu_pkg: shared op encodings and shifter FSM states.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_LUI = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift by up to STEP bits in the direction selected by op.
module shift_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int KW   = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  op_e              op,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] sra;

    // Kept separate so the unsigned ternary below cannot turn >>> into a logical shift.
    always_comb begin
        sra     = $signed(data) >>> k;
        shifted = (op == OP_SRL) ? data >> k :
                  (op == OP_SRA) ? sra :
                                   data << k;
    end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA/LUI unit shifting up to STEP bits per clock.
module iter_shifter
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP     = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out_data
);

    localparam int KW = $clog2(STEP) + 1;
    localparam logic [SHAMT_W-1:0] HALF   = SHAMT_W'(WIDTH / 2);
    localparam logic [SHAMT_W-1:0] STEP_S = SHAMT_W'(STEP);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   out_q, out_d, step_out;
    logic [SHAMT_W-1:0] rem_q, rem_d, k_full;
    logic [KW-1:0]      k;

    always_comb begin
        k_full = (rem_q < STEP_S) ? rem_q : STEP_S;
        k      = k_full[KW-1:0];
    end

    shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .data    (out_q),
        .k       (k),
        .op      (op_q),
        .shifted (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        out_d   = out_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (start) begin
                op_d    = op_e'(op);
                out_d   = in_data;
                rem_d   = (op_e'(op) == OP_LUI) ? HALF : shamt;
                state_d = (rem_d != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                out_d   = step_out;
                rem_d   = rem_q - k_full;
                state_d = (rem_d == '0) ? DONE : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_SLL;
            out_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        ready    = (state_q == IDLE);
        busy     = (state_q == SHIFT) || (state_q == DONE);
        done     = (state_q == DONE);
        out_data = out_q;
    end

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: table-driven and random checks of iter_shifter with a result scoreboard.
module tb_iter_shifter;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din;
        logic [4:0]  sh;
        logic [31:0] exp_out;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        int          lat;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [1:0]  op = 0;
    logic [31:0] in_data = 0;
    logic [4:0]  shamt = 0;
    logic        ready, busy, done;
    logic [31:0] out_data;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .in_data  (in_data),
        .shamt    (shamt),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .out_data (out_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        exp_t r;
        logic signed [31:0] sd;
        int amt;
        sd  = d;
        amt = (o == 2'b11) ? 16 : int'(s);
        case (o)
            2'b00:   r.out = d << amt;
            2'b01:   r.out = d >> amt;
            2'b10:   r.out = sd >>> amt;
            default: r.out = d << 16;
        endcase
        r.lat = 1 + (amt + STEP - 1) / STEP;
        return r;
    endfunction

    // Drives one request, waits for done and checks result, latency and busy span.
    task automatic run(input string name, input logic [1:0] o, input logic [31:0] d,
                       input logic [4:0] s, input exp_t e);
        int cyc, busy_cyc;
        exp_t got;
        exp_q.push_back(e);
        @(negedge clk);
        chk({name, "_ready"}, 32'(ready), 32'd1);
        start = 1; op = o; in_data = d; shamt = s;
        @(negedge clk);
        start = 0;
        cyc = 1;
        busy_cyc = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            busy_cyc += busy ? 1 : 0;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, cyc);
            void'(exp_q.pop_front());
            return;
        end
        got = exp_q.pop_front();
        chk({name, "_out"}, out_data, got.out);
        chk({name, "_lat"}, 32'(cyc), 32'(got.lat));
        chk({name, "_busy"}, 32'(busy_cyc), 32'(got.lat));
        @(negedge clk);
        chk({name, "_ready_after"}, 32'(ready), 32'd1);
        chk({name, "_hold"}, out_data, got.out);
    endtask

    initial begin
        int pulses, cyc;
        exp_t e;
        vecs[0] = '{2'b00, 32'h000000FF, 5'd8,  32'h0000FF00, 3};
        vecs[1] = '{2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 9};
        vecs[2] = '{2'b01, 32'h80000000, 5'd31, 32'h00000001, 9};
        vecs[3] = '{2'b11, 32'h00001234, 5'd5,  32'h12340000, 5};
        vecs[4] = '{2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1};
        vecs[5] = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000, 9};
        vecs[6] = '{2'b10, 32'hF0000000, 5'd6,  32'hFFC00000, 3};
        vecs[7] = '{2'b01, 32'h12345678, 5'd3,  32'h02468ACF, 2};

        repeat (2) @(negedge clk);
        rst_n = 1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", out_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            e.out = vecs[i].exp_out;
            e.lat = vecs[i].exp_lat;
            run($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].sh, e);
        end

        for (int i = 0; i < 20; i++) begin
            logic [1:0]  o;
            logic [31:0] d;
            logic [4:0]  s;
            o = 2'($urandom_range(0, 3));
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            run($sformatf("rnd%0d", i), o, d, s, model(o, d, s));
        end

        // start held high while busy and through the done cycle must be ignored
        @(negedge clk);
        start = 1; op = 2'b00; in_data = 32'h000000FF; shamt = 5'd8;
        @(negedge clk);
        in_data = 32'hFFFFFFFF; shamt = 5'd1; op = 2'b10;
        pulses = 0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        pulses += done ? 1 : 0;
        chk("hs_out", out_data, 32'h0000FF00);
        chk("hs_lat", 32'(cyc), 32'd3);
        start = 0;
        @(negedge clk);
        chk("hs_ready_after", 32'(ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            pulses += done ? 1 : 0;
            @(negedge clk);
        end
        chk("hs_pulses", 32'(pulses), 32'd1);
        chk("hs_out_hold", out_data, 32'h0000FF00);

        // reset mid-SHIFT abandons the operation
        start = 1; op = 2'b00; in_data = 32'h00000001; shamt = 5'd20;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("rs_busy_pre", 32'(busy), 32'd1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("rs_out", out_data, 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_ready", 32'(ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pulses += done ? 1 : 0;
        end
        chk("rs_no_done", 32'(pulses), 32'd0);

        e = model(2'b00, 32'h0000000F, 5'd4);
        run("post_rst", 2'b00, 32'h0000000F, 5'd4, e);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
